// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - pipeline and RAM signal bundle for the shared memory arbiter
interface mem_arbiter_if;
    // fetch side
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_flush;
    logic        imem_r;
    logic [15:0] instr;
    // MEM stage side
    logic        mem_req;
    logic [1:0]  mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        dmem_r;
    logic [15:0] dmem_rdata;
    logic        mem_stall;
    // RAM side
    logic        ram_en;
    logic [1:0]  ram_we;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;

    // arbiter view
    modport slave (
        input  if_req, if_addr, if_flush,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  ram_rdata,
        output imem_r, instr,
        output dmem_r, dmem_rdata, mem_stall,
        output ram_en, ram_we, ram_addr, ram_wdata
    );

    // pipeline / RAM model view
    modport master (
        output if_req, if_addr, if_flush,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output ram_rdata,
        input  imem_r, instr,
        input  dmem_r, dmem_rdata, mem_stall,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fixed-priority arbiter sharing one multi-cycle RAM between fetch and MEM
module mem_arbiter #(
    parameter int MEM_LATENCY = 5,
    parameter int CNT_W       = 3
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_BUSY  = 2'd1,
        MEM_BUSY = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       we_q;
    logic             grant_mem;
    logic             grant_if;
    logic             last;

    assign last = (cnt == '0);

    // next-state: MEM has fixed priority in IDLE; flush only cancels fetch accesses
    always_comb begin
        state_next = state;
        grant_mem  = 1'b0;
        grant_if   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.mem_req) begin
                    grant_mem  = 1'b1;
                    state_next = MEM_BUSY;
                end else if (bus.if_req && !bus.if_flush) begin
                    grant_if   = 1'b1;
                    state_next = IF_BUSY;
                end
            end
            IF_BUSY: begin
                if (bus.if_flush || last) begin
                    state_next = IDLE;
                end
            end
            MEM_BUSY: begin
                if (last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // latency counter: loaded on grant, counts down to the ready cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (grant_mem || grant_if) begin
            cnt <= CNT_INIT;
        end else if (state_next == IDLE) begin
            cnt <= '0;
        end else if (!last) begin
            cnt <= cnt - 1'b1;
        end
    end

    // access registers: captured at the grant edge and held for the whole access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
            we_q          <= '0;
        end else if (grant_mem) begin
            bus.ram_addr  <= bus.mem_addr;
            bus.ram_wdata <= bus.mem_wdata;
            we_q          <= bus.mem_we;
        end else if (grant_if) begin
            bus.ram_addr  <= bus.if_addr;
            bus.ram_wdata <= '0;
            we_q          <= '0;
        end
    end

    // outputs decoded from state; reset clears state so they drop asynchronously
    always_comb begin
        bus.ram_en     = (state != IDLE);
        bus.ram_we     = (state == MEM_BUSY) ? we_q : 2'b00;
        bus.imem_r     = (state == IF_BUSY) && last && !bus.if_flush;
        bus.dmem_r     = (state == MEM_BUSY) && last;
        bus.instr      = bus.imem_r ? bus.ram_rdata : 16'h0000;
        bus.dmem_rdata = (bus.dmem_r && (we_q == 2'b00)) ? bus.ram_rdata : 16'h0000;
        bus.mem_stall  = bus.mem_req && !bus.dmem_r && !reset;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter (latency 5 and latency 1 builds)
module tb_mem_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    always #5 clk = ~clk;

    // cycle index, valid from just after each rising edge
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter_if ia ();
    mem_arbiter_if ib ();

    mem_arbiter #(.MEM_LATENCY(5), .CNT_W(3)) dut_a (.clk(clk), .reset(reset), .bus(ia));
    mem_arbiter #(.MEM_LATENCY(1), .CNT_W(1)) dut_b (.clk(clk), .reset(reset), .bus(ib));

    typedef struct {
        bit          is_mem;
        int          at;
        logic [15:0] data;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;
    int   tests = 0;
    int   fails = 0;
    int   c;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input bit m, input int at, input logic [15:0] d);
        exp_t e;
        e.is_mem = m; e.at = at; e.data = d;
        qa.push_back(e);
    endtask

    task automatic push_b(input bit m, input int at, input logic [15:0] d);
        exp_t e;
        e.is_mem = m; e.at = at; e.data = d;
        qb.push_back(e);
    endtask

    // monitor for the latency-5 arbiter
    always @(negedge clk) begin
        if (ia.imem_r || ia.dmem_r) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_pulse", {30'd0, ia.imem_r, ia.dmem_r}, 32'd0);
            end else begin
                ea = qa.pop_front();
                chk("a_kind", {31'd0, ia.dmem_r}, {31'd0, ea.is_mem});
                chk("a_both", {31'd0, ia.imem_r & ia.dmem_r}, 32'd0);
                chk("a_cycle", cyc, ea.at);
                chk("a_data", ea.is_mem ? ia.dmem_rdata : ia.instr, ea.data);
            end
        end else begin
            chk("a_idle_data", {ia.instr, ia.dmem_rdata}, 32'd0);
        end
    end

    // monitor for the latency-1 arbiter
    always @(negedge clk) begin
        if (ib.imem_r || ib.dmem_r) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_pulse", {30'd0, ib.imem_r, ib.dmem_r}, 32'd0);
            end else begin
                eb = qb.pop_front();
                chk("b_kind", {31'd0, ib.dmem_r}, {31'd0, eb.is_mem});
                chk("b_cycle", cyc, eb.at);
                chk("b_data", eb.is_mem ? ib.dmem_rdata : ib.instr, eb.data);
            end
        end
    end

    initial begin
        ia.if_req = 1'b1; ia.if_addr = 16'h0; ia.if_flush = 1'b0;
        ia.mem_req = 1'b1; ia.mem_we = 2'b00; ia.mem_addr = 16'h0; ia.mem_wdata = 16'h0;
        ia.ram_rdata = 16'h0;
        ib.if_req = 1'b0; ib.if_addr = 16'h0; ib.if_flush = 1'b0;
        ib.mem_req = 1'b0; ib.mem_we = 2'b00; ib.mem_addr = 16'h0; ib.mem_wdata = 16'h0;
        ib.ram_rdata = 16'h0;

        // outputs held at zero during reset even with requests pending
        @(negedge clk);
        chk("rst_ram_en", {31'd0, ia.ram_en}, 32'd0);
        chk("rst_stall", {31'd0, ia.mem_stall}, 32'd0);
        chk("rst_ram_we", {30'd0, ia.ram_we}, 32'd0);
        chk("rst_ram_addr", {16'd0, ia.ram_addr}, 32'd0);
        chk("rst_pulses", {30'd0, ia.imem_r, ia.dmem_r}, 32'd0);
        next_cycle();
        ia.if_req = 1'b0; ia.mem_req = 1'b0;
        reset = 1'b0;
        next_cycle();

        // 1: single fetch, ready 5 cycles after the request
        c = cyc;
        ia.if_req = 1'b1; ia.if_addr = 16'h3000; ia.ram_rdata = 16'h1234;
        push_a(1'b0, c + 5, 16'h1234);
        @(negedge clk);
        chk("t1_en_c0", {31'd0, ia.ram_en}, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            next_cycle();
            @(negedge clk);
            chk("t1_ram_en", {31'd0, ia.ram_en}, 32'd1);
            chk("t1_addr", {16'd0, ia.ram_addr}, 32'h3000);
            chk("t1_we", {30'd0, ia.ram_we}, 32'd0);
        end
        next_cycle();
        ia.if_req = 1'b0;
        @(negedge clk);
        chk("t1_en_after", {31'd0, ia.ram_en}, 32'd0);

        // 2: simultaneous requests, MEM first then fetch
        next_cycle();
        c = cyc;
        ia.if_req = 1'b1; ia.if_addr = 16'h3002;
        ia.mem_req = 1'b1; ia.mem_we = 2'b00; ia.mem_addr = 16'h4000; ia.ram_rdata = 16'hBEEF;
        push_a(1'b1, c + 5, 16'hBEEF);
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) next_cycle();
            @(negedge clk);
            chk("t2_stall", {31'd0, ia.mem_stall}, (k < 5) ? 32'd1 : 32'd0);
            if (k > 0) chk("t2_mem_addr", {16'd0, ia.ram_addr}, 32'h4000);
        end
        next_cycle();
        ia.mem_req = 1'b0; ia.ram_rdata = 16'h0F0F;
        push_a(1'b0, c + 11, 16'h0F0F);
        @(negedge clk);
        chk("t2_stall_off", {31'd0, ia.mem_stall}, 32'd0);
        chk("t2_idle_gap", {31'd0, ia.ram_en}, 32'd0);
        for (int k = 7; k <= 11; k++) begin
            next_cycle();
            @(negedge clk);
            chk("t2_if_en", {31'd0, ia.ram_en}, 32'd1);
            chk("t2_if_addr", {16'd0, ia.ram_addr}, 32'h3002);
        end
        next_cycle();
        ia.if_req = 1'b0;

        // 3: high-byte store
        next_cycle();
        c = cyc;
        ia.mem_req = 1'b1; ia.mem_we = 2'b10; ia.mem_addr = 16'h4001;
        ia.mem_wdata = 16'hAB00; ia.ram_rdata = 16'hFFFF;
        push_a(1'b1, c + 5, 16'h0000);
        for (int k = 1; k <= 5; k++) begin
            next_cycle();
            @(negedge clk);
            chk("t3_ram_we", {30'd0, ia.ram_we}, 32'd2);
            chk("t3_wdata", {16'd0, ia.ram_wdata}, 32'hAB00);
            chk("t3_addr", {16'd0, ia.ram_addr}, 32'h4001);
        end
        next_cycle();
        ia.mem_req = 1'b0; ia.mem_we = 2'b00;
        @(negedge clk);
        chk("t3_we_after", {30'd0, ia.ram_we}, 32'd0);

        // 4a: flush in the third IF_BUSY cycle
        next_cycle();
        ia.if_req = 1'b1; ia.if_addr = 16'h3004; ia.ram_rdata = 16'h5555;
        next_cycle();
        next_cycle();
        next_cycle();
        ia.if_flush = 1'b1;
        @(negedge clk);
        chk("t4a_en_flush", {31'd0, ia.ram_en}, 32'd1);
        next_cycle();
        ia.if_flush = 1'b0; ia.if_req = 1'b0;
        @(negedge clk);
        chk("t4a_en_dropped", {31'd0, ia.ram_en}, 32'd0);
        next_cycle();

        // 4b: flush on the ready cycle suppresses imem_r
        next_cycle();
        ia.if_req = 1'b1; ia.if_addr = 16'h3006;
        repeat (5) next_cycle();
        ia.if_flush = 1'b1;
        @(negedge clk);
        chk("t4b_en_last", {31'd0, ia.ram_en}, 32'd1);
        chk("t4b_no_imem_r", {31'd0, ia.imem_r}, 32'd0);
        next_cycle();
        ia.if_flush = 1'b0; ia.if_req = 1'b0;
        @(negedge clk);
        chk("t4b_en_after", {31'd0, ia.ram_en}, 32'd0);

        // 4c: flush during a data access is ignored
        next_cycle();
        c = cyc;
        ia.mem_req = 1'b1; ia.mem_we = 2'b00; ia.mem_addr = 16'h4002; ia.ram_rdata = 16'h1111;
        push_a(1'b1, c + 5, 16'h1111);
        for (int k = 1; k <= 5; k++) begin
            next_cycle();
            ia.if_flush = 1'b1;
            @(negedge clk);
            chk("t4c_en", {31'd0, ia.ram_en}, 32'd1);
        end
        next_cycle();
        ia.if_flush = 1'b0; ia.mem_req = 1'b0;
        @(negedge clk);
        chk("t4c_en_after", {31'd0, ia.ram_en}, 32'd0);

        // 5: reset in the second MEM_BUSY cycle of a write
        next_cycle();
        ia.mem_req = 1'b1; ia.mem_we = 2'b01; ia.mem_addr = 16'h4010; ia.mem_wdata = 16'h00CD;
        next_cycle();
        next_cycle();
        chk("t5_we_before", {30'd0, ia.ram_we}, 32'd1);
        reset = 1'b1;
        #1;
        chk("t5_we_async", {30'd0, ia.ram_we}, 32'd0);
        chk("t5_en_async", {31'd0, ia.ram_en}, 32'd0);
        ia.mem_req = 1'b0; ia.mem_we = 2'b00;
        @(negedge clk);
        chk("t5_no_dmem_r", {31'd0, ia.dmem_r}, 32'd0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("t5_idle_after", {31'd0, ia.ram_en}, 32'd0);
        next_cycle();
        c = cyc;
        ia.mem_req = 1'b1; ia.mem_addr = 16'h4020; ia.ram_rdata = 16'h2222;
        push_a(1'b1, c + 5, 16'h2222);
        next_cycle();
        @(negedge clk);
        chk("t5_regrant_en", {31'd0, ia.ram_en}, 32'd1);
        chk("t5_regrant_addr", {16'd0, ia.ram_addr}, 32'h4020);
        repeat (4) next_cycle();
        next_cycle();
        ia.mem_req = 1'b0;

        // 6: latency-1 build, back-to-back fetches every two cycles
        next_cycle();
        c = cyc;
        ib.if_req = 1'b1; ib.if_addr = 16'h3100; ib.ram_rdata = 16'hCAFE;
        for (int k = 0; k < 4; k++) push_b(1'b0, c + 1 + 2 * k, 16'hCAFE);
        @(negedge clk);
        chk("t6_en_c0", {31'd0, ib.ram_en}, 32'd0);
        repeat (7) next_cycle();
        next_cycle();
        ib.if_req = 1'b0;
        repeat (3) next_cycle();

        chk("a_sb_empty", qa.size(), 32'd0);
        chk("b_sb_empty", qb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
